// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide unit.
// Multiplies use radix-2 shift-add and divides use restoring shift-subtract.
// Both iterate over operand magnitudes. A final FIX cycle applies the sign
// and selects the result half. Divide-by-zero and signed overflow are
// resolved at accept time and skip the iteration entirely.
//
// Ports:
//   clk    - clock, all state updates on the rising edge
//   reset  - synchronous active-high reset
//   start  - request, accepted only while ready=1 and kill=0
//   op     - funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   a      - rs1 operand (multiplicand / dividend)
//   b      - rs2 operand (multiplier / divisor)
//   kill   - pipeline flush, aborts an operation in flight
//   ready  - high in IDLE and DONE
//   busy   - high in CALC and FIX
//   done   - one-cycle pulse, result valid
//   result - registered result, held until the next completion or reset
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONES    = {XLEN{1'b1}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state, state_next;
  logic [2:0]        op_r;
  logic              neg;
  logic [CW-1:0]     cnt;
  // Multiply: {high partial product, remaining multiplier bits}.
  // Divide: low half holds the dividend shifting out / quotient shifting in.
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   opnd;

  logic              accept;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              special;
  logic [XLEN-1:0]   special_result;

  assign ready  = (state == IDLE) || (state == DONE);
  assign busy   = (state == CALC) || (state == FIX);
  assign accept = ready && start && !kill;

  // Operand signedness from funct3, then magnitudes. The most negative value
  // negates to itself, which read as unsigned is the correct magnitude.
  always_comb begin
    a_neg = a[XLEN-1] && (op == 3'b001 || op == 3'b010 || op == 3'b100 || op == 3'b110);
    b_neg = b[XLEN-1] && (op == 3'b001 || op == 3'b100 || op == 3'b110);
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  // Divide corner cases that finish immediately without iterating.
  always_comb begin
    special        = 1'b0;
    special_result = '0;
    if (op[2]) begin
      if (b == '0) begin
        special        = 1'b1;
        special_result = op[1] ? a : ONES;
      end else if (!op[0] && a == MIN_VAL && b == ONES) begin
        special        = 1'b1;
        special_result = op[1] ? '0 : a;
      end
    end
  end

  // One iteration step for each algorithm. The divide trial subtraction
  // works on an XLEN+1-bit partial remainder so its top bit is the borrow.
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_part;
  logic [XLEN:0]     div_trial;
  logic              div_ok;
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    div_part  = {rem, acc[XLEN-1]};
    div_trial = div_part - {1'b0, opnd};
    div_ok    = !div_trial[XLEN];
  end

  // Sign fix-up and result selection used in the FIX cycle.
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_result;
  always_comb begin
    prod    = neg ? -acc : acc;
    quo_fix = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_fix = neg ? -rem : rem;
    if (op_r[2])
      fix_result = op_r[1] ? rem_fix : quo_fix;
    else if (op_r[1:0] == 2'b00)
      fix_result = prod[XLEN-1:0];
    else
      fix_result = prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= (state_next == DONE);
    end
  end

  // kill aborts CALC/FIX and blocks a same-cycle start from IDLE/DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = special ? DONE : CALC;
      CALC: begin
        if (kill)                      state_next = IDLE;
        else if (cnt == CW'(XLEN - 1)) state_next = FIX;
      end
      FIX:  state_next = kill ? IDLE : DONE;
      DONE: begin
        if (accept) state_next = special ? DONE : CALC;
        else        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_r   <= '0;
      neg    <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      rem    <= '0;
      opnd   <= '0;
      result <= '0;
    end else if (accept) begin
      op_r <= op;
      neg  <= op[2] && op[1] ? a_neg : (a_neg ^ b_neg);
      cnt  <= '0;
      rem  <= '0;
      if (special) begin
        result <= special_result;
      end else if (op[2]) begin
        acc  <= {{XLEN{1'b0}}, a_mag};
        opnd <= b_mag;
      end else begin
        acc  <= {{XLEN{1'b0}}, b_mag};
        opnd <= a_mag;
      end
    end else if (state == CALC) begin
      cnt <= cnt + CW'(1);
      if (op_r[2]) begin
        rem <= div_ok ? div_trial[XLEN-1:0] : div_part[XLEN-1:0];
        acc <= {acc[2*XLEN-1:XLEN], acc[XLEN-2:0], div_ok};
      end else begin
        acc <= {mul_sum, acc[XLEN-1:1]};
      end
    end else if (state == FIX && !kill) begin
      result <= fix_result;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed, table-driven bench for muldiv_unit (XLEN=32).
// Vectors check result and latency; hand sequences cover ignored start,
// back-to-back issue, kill, kill+start and reset mid-operation.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        kill;
  logic        ready, busy, done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .kill(kill), .ready(ready), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Issue one op and wait for done; lat counts cycles after the accept edge.
  task automatic apply_stimulus(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] res, output int lat);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = result;
  endtask

  // Count done pulses over n cycles.
  task automatic count_done(input int n, output int pulses);
    pulses = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (done) pulses++;
    end
  endtask

  initial begin
    logic [31:0] res;
    int lat, pulses;

    vecs[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34};
    vecs[1]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34};
    vecs[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34};
    vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34};
    vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34};
    vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34};
    vecs[6]  = '{3'b101, 32'd100,      32'd7,        32'd14,       34};
    vecs[7]  = '{3'b111, 32'd100,      32'd7,        32'd2,        34};
    vecs[8]  = '{3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
    vecs[9]  = '{3'b110, 32'd5,        32'd0,        32'd5,        1};
    vecs[10] = '{3'b111, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 1};
    vecs[11] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[12] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
    vecs[13] = '{3'b000, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'd15,       34};
    vecs[14] = '{3'b100, 32'd50,       32'hFFFFFFF9, 32'hFFFFFFF9, 34};

    reset = 1'b1; start = 1'b0; kill = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_output("reset_ready",  {31'd0, ready}, 32'd1);
    check_output("reset_busy",   {31'd0, busy},  32'd0);
    check_output("reset_done",   {31'd0, done},  32'd0);
    check_output("reset_result", result,         32'd0);

    for (int i = 0; i < 15; i++) begin
      apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
      check_output($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check_output($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
    end

    // start during a MUL is ignored.
    @(negedge clk);
    op = 3'b000; a = 32'd7; b = 32'hFFFFFFFD; start = 1'b1;
    @(negedge clk);
    lat = 1;
    start = 1'b0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
      start = (lat == 5);
      if (lat == 5) begin op = 3'b011; a = 32'd5; b = 32'd5; end
    end
    start = 1'b0;
    check_output("ignored_start_result", result, 32'hFFFFFFEB);
    check_output("ignored_start_latency", lat, 34);

    // Back-to-back: new start in the DONE cycle.
    apply_stimulus(3'b101, 32'd100, 32'd7, res, lat);
    check_output("b2b_first_result", res, 32'd14);
    op = 3'b111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    check_output("b2b_busy", {31'd0, busy}, 32'd1);
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check_output("b2b_second_result", result, 32'd2);
    check_output("b2b_second_latency", lat, 34);

    // kill at T+10 of a DIV.
    @(negedge clk);
    op = 3'b100; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check_output("kill_busy",   {31'd0, busy},  32'd0);
    check_output("kill_ready",  {31'd0, ready}, 32'd1);
    check_output("kill_result", result,         32'd2);
    count_done(40, pulses);
    check_output("kill_no_done", pulses, 0);

    // kill with start in the same idle cycle.
    @(negedge clk);
    op = 3'b000; a = 32'd9; b = 32'd9; start = 1'b1; kill = 1'b1;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    check_output("killstart_busy", {31'd0, busy}, 32'd0);
    count_done(40, pulses);
    check_output("killstart_no_done", pulses, 0);
    check_output("killstart_result", result, 32'd2);

    // reset at T+20 of a MUL.
    @(negedge clk);
    op = 3'b000; a = 32'd5; b = 32'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_output("rst_mid_result", result,         32'd0);
    check_output("rst_mid_done",   {31'd0, done},  32'd0);
    check_output("rst_mid_ready",  {31'd0, ready}, 32'd1);
    count_done(40, pulses);
    check_output("rst_mid_no_done", pulses, 0);
    apply_stimulus(3'b000, 32'd3, 32'd4, res, lat);
    check_output("after_rst_mul", res, 32'd12);
    check_output("after_rst_latency", lat, 34);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
